// File: rtl/dkong_dma_if.sv
// Bus bundle for the object-RAM DMA: programming slave port, master bus and trigger/status.
interface dkong_dma_if;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned RW = 4;

    logic          ena;
    logic [RW-1:0] s_addr;
    logic          s_rdn;
    logic          s_wrn;
    logic [DW-1:0] s_din;
    logic [DW-1:0] s_dout;
    logic          s_mwait;
    logic          dma_rdy;
    logic          bus_req;
    logic          bus_gnt;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_dout;
    logic [DW-1:0] m_din;
    logic          m_mwait;
    logic          m_mreqn;
    logic          m_rdn;
    logic          m_wrn;
    logic          busy;
    logic          done;

    // DMA engine view (it masters the system bus)
    modport master (
        input  ena, s_addr, s_rdn, s_wrn, s_din, dma_rdy, bus_gnt, m_din, m_mwait,
        output s_dout, s_mwait, bus_req, m_addr, m_dout, m_mreqn, m_rdn, m_wrn, busy, done
    );

    // System side: CPU decode, mux and memories
    modport slave (
        output ena, s_addr, s_rdn, s_wrn, s_din, dma_rdy, bus_gnt, m_din, m_mwait,
        input  s_dout, s_mwait, bus_req, m_addr, m_dout, m_mreqn, m_rdn, m_wrn, busy, done
    );
endinterface

// File: rtl/dkong_dma.sv
// Single-channel work-RAM to object-RAM copy engine with a small programming register file.
module dkong_dma #(
    parameter logic [15:0] SRC_RST = 16'h6900,
    parameter logic [15:0] DST_RST = 16'h7000,
    parameter logic [15:0] CNT_RST = 16'h0180
) (
    input logic         clk,
    input logic         rst,
    dkong_dma_if.master bus
);
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;

    typedef enum logic [2:0] {IDLE, REQ, RD1, RD2, WR1, WR2, FIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] src_q, src_d, dst_q, dst_d, cnt_q, cnt_d;
    logic [AW-1:0] wsrc_q, wsrc_d, wdst_q, wdst_d, wcnt_q, wcnt_d;
    logic [DW-1:0] latch_q, latch_d;
    logic          rdy_prev_q, rdy_prev_d;
    logic          done_stk_q, done_stk_d;
    logic          ovr_q, ovr_d;
    logic          stall_q, stall_d;
    logic [DW-1:0] s_dout_q, s_dout_d;
    logic          bus_req_q, bus_req_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_dout_q, m_dout_d;
    logic          m_mreqn_q, m_mreqn_d;
    logic          m_rdn_q, m_rdn_d;
    logic          m_wrn_q, m_wrn_d;
    logic          trig;
    logic          rd_ph, wr_ph;

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        cnt_d      = cnt_q;
        wsrc_d     = wsrc_q;
        wdst_d     = wdst_q;
        wcnt_d     = wcnt_q;
        latch_d    = latch_q;
        rdy_prev_d = bus.dma_rdy;
        done_stk_d = done_stk_q;
        ovr_d      = ovr_q;
        stall_d    = stall_q;
        s_dout_d   = s_dout_q;
        done_d     = 1'b0;
        trig       = bus.dma_rdy & ~rdy_prev_q;

        // Programming port; the sticky-clear sits before the FSM so a same-cycle set wins
        if (bus.ena && !bus.s_wrn) begin
            case (bus.s_addr)
                4'h0:    src_d[7:0]  = bus.s_din;
                4'h1:    src_d[15:8] = bus.s_din;
                4'h2:    dst_d[7:0]  = bus.s_din;
                4'h3:    dst_d[15:8] = bus.s_din;
                4'h4:    cnt_d[7:0]  = bus.s_din;
                4'h5:    cnt_d[15:8] = bus.s_din;
                default: ;
            endcase
        end
        if (bus.ena && !bus.s_rdn) begin
            case (bus.s_addr)
                4'h0:    s_dout_d = src_q[7:0];
                4'h1:    s_dout_d = src_q[15:8];
                4'h2:    s_dout_d = dst_q[7:0];
                4'h3:    s_dout_d = dst_q[15:8];
                4'h4:    s_dout_d = cnt_q[7:0];
                4'h5:    s_dout_d = cnt_q[15:8];
                4'h6: begin
                    s_dout_d   = {5'b00000, ovr_q, done_stk_q, busy_q};
                    done_stk_d = 1'b0;
                    ovr_d      = 1'b0;
                end
                default: s_dout_d = 8'h00;
            endcase
        end

        if (trig && state_q != IDLE) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (trig) begin
                    if (cnt_q != 16'h0000) begin
                        wsrc_d  = src_q;
                        wdst_d  = dst_q;
                        wcnt_d  = cnt_q;
                        state_d = REQ;
                    end else begin
                        done_d     = 1'b1;
                        done_stk_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (bus.bus_gnt) begin
                    state_d = RD1;
                end
            end
            RD1, RD2, WR1, WR2: begin
                // Lost grant parks the FSM; the interrupted byte restarts from its read
                if (!bus.bus_gnt) begin
                    stall_d = 1'b1;
                end else if (stall_q) begin
                    stall_d = 1'b0;
                    state_d = RD1;
                end else begin
                    case (state_q)
                        RD1: state_d = RD2;
                        RD2: begin
                            if (bus.m_mwait) begin
                                latch_d = bus.m_din;
                                state_d = WR1;
                            end
                        end
                        WR1: state_d = WR2;
                        default: begin
                            if (bus.m_mwait) begin
                                wsrc_d  = wsrc_q + 16'd1;
                                wdst_d  = wdst_q + 16'd1;
                                wcnt_d  = wcnt_q - 16'd1;
                                state_d = (wcnt_q == 16'd1) ? FIN : RD1;
                            end
                        end
                    endcase
                end
            end
            FIN: begin
                done_d     = 1'b1;
                done_stk_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Bus outputs are registered from the next state so strobes change cleanly on edges
        rd_ph     = (state_d == RD1 || state_d == RD2) && !stall_d;
        wr_ph     = (state_d == WR1 || state_d == WR2) && !stall_d;
        bus_req_d = (state_d != IDLE);
        busy_d    = (state_d != IDLE);
        m_addr_d  = rd_ph ? wsrc_d : (wr_ph ? wdst_d : 16'h0000);
        m_dout_d  = wr_ph ? latch_d : 8'h00;
        m_mreqn_d = ~(rd_ph | wr_ph);
        m_rdn_d   = ~rd_ph;
        m_wrn_d   = ~wr_ph;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= SRC_RST;
            dst_q      <= DST_RST;
            cnt_q      <= CNT_RST;
            wsrc_q     <= 16'h0000;
            wdst_q     <= 16'h0000;
            wcnt_q     <= 16'h0000;
            latch_q    <= 8'h00;
            rdy_prev_q <= 1'b0;
            done_stk_q <= 1'b0;
            ovr_q      <= 1'b0;
            stall_q    <= 1'b0;
            s_dout_q   <= 8'h00;
            bus_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            m_addr_q   <= 16'h0000;
            m_dout_q   <= 8'h00;
            m_mreqn_q  <= 1'b1;
            m_rdn_q    <= 1'b1;
            m_wrn_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            cnt_q      <= cnt_d;
            wsrc_q     <= wsrc_d;
            wdst_q     <= wdst_d;
            wcnt_q     <= wcnt_d;
            latch_q    <= latch_d;
            rdy_prev_q <= rdy_prev_d;
            done_stk_q <= done_stk_d;
            ovr_q      <= ovr_d;
            stall_q    <= stall_d;
            s_dout_q   <= s_dout_d;
            bus_req_q  <= bus_req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            m_addr_q   <= m_addr_d;
            m_dout_q   <= m_dout_d;
            m_mreqn_q  <= m_mreqn_d;
            m_rdn_q    <= m_rdn_d;
            m_wrn_q    <= m_wrn_d;
        end
    end

    assign bus.s_dout  = s_dout_q;
    assign bus.s_mwait = 1'b1;
    assign bus.bus_req = bus_req_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_dout  = m_dout_q;
    assign bus.m_mreqn = m_mreqn_q;
    assign bus.m_rdn   = m_rdn_q;
    assign bus.m_wrn   = m_wrn_q;
endmodule

// File: tb/tb_dkong_dma.sv
// Directed bench for dkong_dma: scoreboarded copies, wrap, wait states, zero count and mid-copy reset.
module tb_dkong_dma;
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;
    typedef struct packed {
        logic [31:0] cyc;
        logic [15:0] addr;
    } rd_t;

    logic clk = 1'b0;
    logic rst;
    logic gnt_en;
    logic din_ovr_en;
    logic [7:0] din_ovr;
    logic [7:0] ram_q;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;
    int req_rise_cyc = 0;
    int done_cyc = 0;
    logic wr_prev = 1'b0, rd_prev = 1'b0, req_prev = 1'b0, req_seen = 1'b0;
    wr_t exp_q[$];
    rd_t rd_q[$];
    wr_t e_w;

    dkong_dma_if bus();

    dkong_dma u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] seed(input logic [15:0] a);
        return {a[6:0], a[7]} ^ a[15:8] ^ 8'h5A;
    endfunction

    // Synchronous RAM with one-cycle read latency; optional override of the read bus
    always @(posedge clk or posedge rst) begin
        if (rst) ram_q <= 8'h00;
        else if (!bus.m_mreqn && !bus.m_rdn) ram_q <= seed(bus.m_addr);
    end
    assign bus.m_din   = din_ovr_en ? din_ovr : ram_q;
    assign bus.bus_gnt = bus.bus_req & gnt_en;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: write completions are scoreboarded, read starts and done pulses time-stamped
    always @(negedge clk) begin
        if (!bus.m_mreqn && !bus.m_wrn && wr_prev && bus.m_mwait) begin
            wr_cnt++;
            if (exp_q.size() != 0) begin
                e_w = exp_q.pop_front();
                check("wr_addr", 32'(bus.m_addr), 32'(e_w.addr));
                check("wr_data", 32'(bus.m_dout), 32'(e_w.data));
            end
        end
        if (!bus.m_mreqn && !bus.m_rdn && !rd_prev) rd_q.push_back({32'(cyc), bus.m_addr});
        if (bus.bus_req && !req_prev) req_rise_cyc = cyc;
        if (bus.bus_req) req_seen = 1'b1;
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        wr_prev  = !bus.m_mreqn && !bus.m_wrn;
        rd_prev  = !bus.m_mreqn && !bus.m_rdn;
        req_prev = bus.bus_req;
    end

    task automatic reg_wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.ena = 1'b1; bus.s_addr = a; bus.s_din = d; bus.s_wrn = 1'b0;
        @(negedge clk);
        bus.ena = 1'b0; bus.s_wrn = 1'b1;
    endtask

    task automatic reg_rd(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.ena = 1'b1; bus.s_addr = a; bus.s_rdn = 1'b0;
        @(negedge clk);
        bus.ena = 1'b0; bus.s_rdn = 1'b1;
        d = bus.s_dout;
    endtask

    task automatic wr16(input logic [3:0] a, input logic [15:0] v);
        reg_wr(a, v[7:0]);
        reg_wr(4'(a + 4'd1), v[15:8]);
    endtask

    task automatic rd16(input logic [3:0] a, output logic [15:0] v);
        logic [7:0] lo, hi;
        reg_rd(a, lo);
        reg_rd(4'(a + 4'd1), hi);
        v = {hi, lo};
    endtask

    task automatic trigger();
        @(negedge clk);
        bus.dma_rdy = 1'b1;
        @(negedge clk);
        bus.dma_rdy = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check(tag, 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic push_copy(input logic [15:0] src, input logic [15:0] dst, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({16'(dst + 16'(i)), seed(16'(src + 16'(i)))});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  b;
        logic [15:0] v;
        int w0, d0, n;

        rst = 1'b1; gnt_en = 1'b1; din_ovr_en = 1'b0; din_ovr = 8'h00;
        bus.ena = 1'b0; bus.s_addr = 4'h0; bus.s_rdn = 1'b1; bus.s_wrn = 1'b1; bus.s_din = 8'h00;
        bus.dma_rdy = 1'b0; bus.m_mwait = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_bus_req", 32'(bus.bus_req), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_m_addr", 32'(bus.m_addr), 32'h0000);
        check("rst_m_dout", 32'(bus.m_dout), 32'h00);
        check("rst_strobes", 32'({bus.m_mreqn, bus.m_rdn, bus.m_wrn}), 32'h7);
        check("rst_s_dout", 32'(bus.s_dout), 32'h00);
        check("s_mwait", 32'(bus.s_mwait), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        rd16(4'h0, v); check("rst_src", 32'(v), 32'h6900);
        rd16(4'h2, v); check("rst_dst", 32'(v), 32'h7000);
        rd16(4'h4, v); check("rst_cnt", 32'(v), 32'h0180);
        reg_rd(4'h6, b); check("rst_status", 32'(b), 32'h00);
        reg_wr(4'h9, 8'h55);
        reg_rd(4'h9, b); check("off9_read", 32'(b), 32'h00);

        // Default 384-byte copy with immediate grant
        push_copy(16'h6900, 16'h7000, 384);
        rd_q.delete(); w0 = wr_cnt; d0 = done_cnt;
        trigger();
        wait_done("t1_done_seen", 2000);
        check("t1_req_to_done", 32'(done_cyc - req_rise_cyc), 32'd1538);
        check("t1_wr_count", 32'(wr_cnt - w0), 32'd384);
        check("t1_rd_count", 32'(rd_q.size()), 32'd384);
        check("t1_sb_empty", 32'(exp_q.size()), 32'd0);
        check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t1_byte_cycles", rd_q[1].cyc - rd_q[0].cyc, 32'd4);
        check("t1_busy_after", 32'(bus.busy), 32'd0);
        reg_rd(4'h6, b); check("t1_status1", 32'(b), 32'h02);
        reg_rd(4'h6, b); check("t1_status2", 32'(b), 32'h00);

        // Address wrap, overrun trigger and register write while busy
        wr16(4'h0, 16'hFFFE); wr16(4'h2, 16'h0010); wr16(4'h4, 16'h0004);
        push_copy(16'hFFFE, 16'h0010, 4);
        rd_q.delete(); w0 = wr_cnt; d0 = done_cnt;
        trigger();
        repeat (3) @(negedge clk);
        check("t2_busy_mid", 32'(bus.busy), 32'd1);
        trigger();
        reg_wr(4'h4, 8'h02);
        wait_done("t2_done_seen", 200);
        for (int i = 0; i < 4; i++) check("t2_rd_addr", 32'(rd_q[i].addr), 32'(16'(16'hFFFE + 16'(i))));
        check("t2_wr_count", 32'(wr_cnt - w0), 32'd4);
        check("t2_sb_empty", 32'(exp_q.size()), 32'd0);
        check("t2_done_pulses", 32'(done_cnt - d0), 32'd1);
        reg_rd(4'h6, b); check("t2_status1", 32'(b), 32'h06);
        reg_rd(4'h6, b); check("t2_status2", 32'(b), 32'h00);
        rd16(4'h4, v); check("t2_cnt_prog", 32'(v), 32'h0002);

        // Wait states: 3 in the first RD2, 2 in the first WR2; data taken at the release sample
        wr16(4'h0, 16'h1234); wr16(4'h2, 16'h2000);
        exp_q.push_back({16'h2000, 8'hA5});
        exp_q.push_back({16'h2001, seed(16'h1235)});
        rd_q.delete(); w0 = wr_cnt;
        trigger();
        n = 0;
        while (bus.m_rdn && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t3_rd_seen", 32'(bus.m_rdn), 32'd0);
        @(posedge clk); #2;
        bus.m_mwait = 1'b0; din_ovr_en = 1'b1; din_ovr = 8'h3C;
        repeat (3) @(posedge clk);
        #2;
        bus.m_mwait = 1'b1; din_ovr = 8'hA5;
        @(posedge clk); #2;
        din_ovr_en = 1'b0;
        @(posedge clk); #2;
        bus.m_mwait = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        bus.m_mwait = 1'b1;
        wait_done("t3_done_seen", 200);
        check("t3_first_byte_cycles", rd_q[1].cyc - rd_q[0].cyc, 32'd9);
        check("t3_wr_count", 32'(wr_cnt - w0), 32'd2);
        check("t3_sb_empty", 32'(exp_q.size()), 32'd0);
        reg_rd(4'h6, b); check("t3_status", 32'(b), 32'h02);

        // Zero count: immediate done, no bus request
        wr16(4'h4, 16'h0000);
        @(negedge clk);
        req_seen = 1'b0; d0 = done_cnt;
        bus.dma_rdy = 1'b1;
        @(negedge clk);
        check("t4_done_pulse", 32'(bus.done), 32'd1);
        check("t4_bus_req", 32'(bus.bus_req), 32'd0);
        check("t4_busy", 32'(bus.busy), 32'd0);
        bus.dma_rdy = 1'b0;
        @(negedge clk);
        check("t4_done_single", 32'(bus.done), 32'd0);
        repeat (3) @(negedge clk);
        check("t4_no_req", 32'(req_seen), 32'd0);
        check("t4_done_count", 32'(done_cnt - d0), 32'd1);
        reg_rd(4'h6, b); check("t4_status1", 32'(b), 32'h02);
        reg_rd(4'h6, b); check("t4_status2", 32'(b), 32'h00);

        // Reset at byte 100 of a default copy, then a full copy afterwards
        wr16(4'h0, 16'h1111); wr16(4'h2, 16'h2222); wr16(4'h4, 16'h0180);
        wr16(4'h0, 16'h6900); wr16(4'h2, 16'h7000);
        push_copy(16'h6900, 16'h7000, 384);
        w0 = wr_cnt; d0 = done_cnt;
        trigger();
        n = 0;
        while (wr_cnt - w0 < 100 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("t5_reached_100", 32'(wr_cnt - w0 >= 100), 32'd1);
        wr16(4'h0, 16'hABCD);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("t5_rst_bus_req", 32'(bus.bus_req), 32'd0);
        check("t5_rst_strobes", 32'({bus.m_mreqn, bus.m_rdn, bus.m_wrn}), 32'h7);
        check("t5_rst_busy", 32'(bus.busy), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        rst = 1'b0;
        rd16(4'h0, v); check("t5_src", 32'(v), 32'h6900);
        rd16(4'h2, v); check("t5_dst", 32'(v), 32'h7000);
        rd16(4'h4, v); check("t5_cnt", 32'(v), 32'h0180);
        push_copy(16'h6900, 16'h7000, 384);
        w0 = wr_cnt;
        trigger();
        wait_done("t5_done_seen", 2000);
        check("t5_wr_count", 32'(wr_cnt - w0), 32'd384);
        check("t5_sb_empty", 32'(exp_q.size()), 32'd0);
        reg_rd(4'h6, b); check("t5_status", 32'(b), 32'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
